// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the memory port and the execute-stage handshake
// of the fetch/sequencing controller.
//   master : the controller (drives o_*, samples i_*)
//   slave  : memory + execute side (drives i_*, samples o_*)
interface fetch_ctrl_if;
    logic [31:0] o_mem_addr;
    logic        o_mem_write;
    logic [7:0]  o_mem_data;
    logic [7:0]  i_mem_data;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_ex_valid;
    logic        i_ex_done;
    logic        i_pc_change;
    logic [31:0] i_new_pc;
    logic [31:0] i_ex_mem_addr;
    logic        i_ex_mem_write;
    logic [7:0]  i_ex_mem_data;
    logic [7:0]  o_ex_mem_data;
    logic        i_halt;
    logic        o_halted;
    logic        o_fault;
    logic [31:0] o_retired;

    modport master (
        output o_mem_addr, o_mem_write, o_mem_data, o_inst, o_pc, o_ex_valid,
               o_ex_mem_data, o_halted, o_fault, o_retired,
        input  i_mem_data, i_ex_done, i_pc_change, i_new_pc, i_ex_mem_addr,
               i_ex_mem_write, i_ex_mem_data, i_halt
    );

    modport slave (
        input  o_mem_addr, o_mem_write, o_mem_data, o_inst, o_pc, o_ex_valid,
               o_ex_mem_data, o_halted, o_fault, o_retired,
        output i_mem_data, i_ex_done, i_pc_change, i_new_pc, i_ex_mem_addr,
               i_ex_mem_write, i_ex_mem_data, i_halt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing control for the multi-cycle RV32I core.
// Fetches each instruction as four little-endian byte reads over the shared
// byte-wide memory port, hands it to execute, waits for completion and
// updates the PC. The memory port belongs to fetch in FETCH and to execute
// in EXEC; it is idle otherwise.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus (master)   memory port, instruction/PC to execute, execute handshake,
//                  halt request, halted/fault status, retired count
//
// state | meaning
// FETCH | reading byte k (0..3) of the instruction at o_pc
// EXEC  | execute owns the instruction and the memory port
// HALT  | idle after a halted instruction boundary, resumes when i_halt drops
// FAULT | misaligned next PC; only reset leaves
module fetch_ctrl #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic          i_clk,
    input logic          i_rst,
    fetch_ctrl_if.master bus
);
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;

    logic [31:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_data;
    logic [7:0]  ex_mem_data;

    assign next_pc = bus.i_pc_change ? bus.i_new_pc : pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        mem_addr    = 32'd0;
        mem_write   = 1'b0;
        mem_data    = 8'd0;
        ex_mem_data = 8'd0;
        case (state_q)
            ST_FETCH: begin
                mem_addr = pc_q + {30'd0, k_q};
                inst_d[int'(k_q)*DATA_WIDTH +: DATA_WIDTH] = bus.i_mem_data;
                // k is 2 bits wide, so it returns to 0 after the last byte
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                mem_addr    = bus.i_ex_mem_addr;
                mem_write   = bus.i_ex_mem_write;
                mem_data    = bus.i_ex_mem_data;
                ex_mem_data = bus.i_mem_data;
                if (bus.i_ex_done) begin
                    retired_d = retired_q + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        // PC stays on the faulting instruction for debug
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = bus.i_halt ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.i_halt) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_FETCH;
            k_q       <= 2'd0;
            inst_q    <= 32'd0;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign bus.o_mem_addr    = mem_addr;
    assign bus.o_mem_write   = mem_write;
    assign bus.o_mem_data    = mem_data;
    assign bus.o_ex_mem_data = ex_mem_data;
    assign bus.o_inst        = inst_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_retired     = retired_q;
    assign bus.o_ex_valid    = (state_q == ST_EXEC);
    assign bus.o_halted      = (state_q == ST_HALT) || (state_q == ST_FAULT);
    assign bus.o_fault       = (state_q == ST_FAULT);
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    logic preload;
    int   checks;
    int   errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.DATA_WIDTH(8), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: combinational read, write on rising edge. Preloaded once.
    logic [7:0] mem [0:1023];
    assign bus.i_mem_data = mem[bus.o_mem_addr[9:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) begin
                if (i == 0)                         mem[i] <= 8'h13;
                else if (i == 2)                    mem[i] <= 8'h10;
                else if (i == 1 || i == 3)          mem[i] <= 8'h00;
                else if (i >= 32'h3C0 && i < 32'h3FC) mem[i] <= 8'h00;
                else                                mem[i] <= 8'($urandom);
            end
        end else if (bus.o_mem_write) begin
            mem[bus.o_mem_addr[9:0]] <= bus.o_mem_data;
        end
    end

    // Reference model: architectural PC, retired count, fault/halt flags
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_fault;
    logic        m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_ex_done      = 1'b0;
        bus.i_pc_change    = 1'b0;
        bus.i_new_pc       = 32'd0;
        bus.i_ex_mem_addr  = 32'd0;
        bus.i_ex_mem_write = 1'b0;
        bus.i_ex_mem_data  = 8'd0;
        bus.i_halt         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_ret   = 32'd0;
        m_fault = 1'b0;
        m_halt  = 1'b0;
    endtask

    // Runs one instruction starting from FETCH byte 0. During fetch an
    // execute-side write to 0x3F0 is requested and must be ignored.
    task automatic do_instr(input logic chg, input logic [31:0] tgt, input int delay,
                            input logic halt, input logic do_wr,
                            input logic [9:0] wa, input logic [7:0] wd);
        logic [31:0] exp_inst;
        logic [31:0] a;
        logic [31:0] nxt;
        logic [7:0]  pre;
        for (int b = 0; b < 4; b++) begin
            a = m_pc + 32'(b);
            exp_inst[8*b +: 8] = mem[a[9:0]];
        end
        bus.i_ex_done      = 1'b0;
        bus.i_ex_mem_write = 1'b1;
        bus.i_ex_mem_addr  = 32'h3F0;
        bus.i_ex_mem_data  = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            bus.i_halt = 1'($urandom);
            #1;
            chk("fetch_addr", bus.o_mem_addr, m_pc + 32'(b));
            chk1("fetch_write", bus.o_mem_write, 1'b0);
            chk1("fetch_valid", bus.o_ex_valid, 1'b0);
            chk("fetch_exdata", 32'(bus.o_ex_mem_data), 32'd0);
            @(negedge clk);
        end
        chk1("exec_valid", bus.o_ex_valid, 1'b1);
        chk("exec_inst", bus.o_inst, exp_inst);
        chk("exec_pc", bus.o_pc, m_pc);
        pre = mem[wa];
        for (int c = 0; c <= delay; c++) begin
            bus.i_ex_mem_write = (c == 0) ? do_wr : 1'b0;
            bus.i_ex_mem_addr  = {22'd0, wa};
            bus.i_ex_mem_data  = wd;
            if (c == delay) begin
                bus.i_ex_done   = 1'b1;
                bus.i_pc_change = chg;
                bus.i_new_pc    = tgt;
                bus.i_halt      = halt;
            end else begin
                bus.i_halt      = 1'($urandom);
            end
            #1;
            chk1("exec_valid_hold", bus.o_ex_valid, 1'b1);
            if (c == 0) begin
                chk1("exec_write", bus.o_mem_write, do_wr);
                chk("exec_addr", bus.o_mem_addr, {22'd0, wa});
                chk("exec_rdata", 32'(bus.o_ex_mem_data), 32'(pre));
                if (do_wr) chk("exec_wdata", 32'(bus.o_mem_data), 32'(wd));
            end
            @(negedge clk);
            if (c == 0 && do_wr) chk("mem_written", 32'(mem[wa]), 32'(wd));
        end
        bus.i_ex_done      = 1'b0;
        bus.i_pc_change    = 1'b0;
        bus.i_ex_mem_write = 1'b0;
        m_ret = m_ret + 32'd1;
        nxt   = chg ? tgt : m_pc + 32'd4;
        if (nxt[1:0] != 2'b00) m_fault = 1'b1;
        else begin
            m_pc   = nxt;
            m_halt = halt;
        end
        #1;
        chk("after_pc", bus.o_pc, m_pc);
        chk("after_retired", bus.o_retired, m_ret);
        chk1("after_fault", bus.o_fault, m_fault);
        chk1("after_halted", bus.o_halted, m_fault | m_halt);
        chk1("after_valid", bus.o_ex_valid, 1'b0);
    endtask

    // Sits in HALT for n cycles with a stray write request, then releases.
    task automatic hold_and_resume(input int n);
        for (int c = 0; c < n; c++) begin
            bus.i_ex_mem_write = 1'b1;
            bus.i_ex_mem_addr  = 32'h3F0;
            #1;
            chk1("halt_halted", bus.o_halted, 1'b1);
            chk1("halt_write", bus.o_mem_write, 1'b0);
            chk("halt_addr", bus.o_mem_addr, 32'd0);
            chk("halt_pc", bus.o_pc, m_pc);
            @(negedge clk);
        end
        bus.i_halt         = 1'b0;
        bus.i_ex_mem_write = 1'b0;
        #1;
        chk1("halt_drop_still", bus.o_halted, 1'b1);
        @(negedge clk);
        m_halt = 1'b0;
    endtask

    typedef struct {
        logic        chg;
        logic [31:0] tgt;
        int          delay;
        logic        halt;
        logic        do_wr;
        logic [9:0]  wa;
        logic [7:0]  wd;
        logic [31:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    vec_t vec [6];

    initial begin
        checks  = 0;
        errors  = 0;
        preload = 1'b1;
        rst     = 1'b1;
        idle_inputs();
        vec[0] = '{1'b0, 32'h0,        0, 1'b0, 1'b0, 10'h3C0, 8'h00, 32'h0000_0004, 1'b0};
        vec[1] = '{1'b1, 32'h100,      2, 1'b0, 1'b1, 10'h040, 8'hA5, 32'h0000_0100, 1'b0};
        vec[2] = '{1'b0, 32'h0,        1, 1'b0, 1'b0, 10'h3C1, 8'h00, 32'h0000_0104, 1'b0};
        vec[3] = '{1'b1, 32'hFFFFFFFC, 0, 1'b0, 1'b1, 10'h3C2, 8'h5A, 32'hFFFF_FFFC, 1'b0};
        vec[4] = '{1'b0, 32'h0,        3, 1'b0, 1'b0, 10'h3C3, 8'h00, 32'h0000_0000, 1'b0};
        vec[5] = '{1'b1, 32'h20,       1, 1'b1, 1'b0, 10'h3C4, 8'h00, 32'h0000_0020, 1'b1};
        @(negedge clk);
        preload = 1'b0;
        do_reset();

        #1;
        chk("rst_pc", bus.o_pc, 32'h0);
        chk("rst_inst", bus.o_inst, 32'h0);
        chk("rst_retired", bus.o_retired, 32'd0);
        chk1("rst_valid", bus.o_ex_valid, 1'b0);
        chk1("rst_halted", bus.o_halted, 1'b0);
        chk1("rst_fault", bus.o_fault, 1'b0);
        chk("rst_addr", bus.o_mem_addr, 32'h0);

        for (int i = 0; i < 6; i++) begin
            do_instr(vec[i].chg, vec[i].tgt, vec[i].delay, vec[i].halt,
                     vec[i].do_wr, vec[i].wa, vec[i].wd);
            if (i == 0) chk("t1_inst", bus.o_inst, 32'h0010_0013);
            chk("tbl_pc", bus.o_pc, vec[i].exp_pc);
            chk("tbl_retired", bus.o_retired, 32'(i + 1));
            chk1("tbl_halted", bus.o_halted, vec[i].exp_halted);
            if (vec[i].exp_halted) hold_and_resume(3);
        end

        // misaligned target: fault, PC frozen, port idle until reset
        do_instr(1'b1, 32'h102, 0, 1'b0, 1'b0, 10'h3C5, 8'h00);
        for (int c = 0; c < 4; c++) begin
            bus.i_ex_mem_write = 1'b1;
            bus.i_ex_mem_addr  = 32'h3F0;
            #1;
            chk1("fault_flag", bus.o_fault, 1'b1);
            chk1("fault_halted", bus.o_halted, 1'b1);
            chk("fault_pc", bus.o_pc, 32'h20);
            chk1("fault_write", bus.o_mem_write, 1'b0);
            chk("fault_addr", bus.o_mem_addr, 32'h0);
            @(negedge clk);
        end

        // reset in the middle of a fetch (byte k=2)
        do_reset();
        do_instr(1'b1, 32'h80, 0, 1'b0, 1'b0, 10'h3C6, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0; m_ret = 32'd0; m_fault = 1'b0; m_halt = 1'b0;
        #1;
        chk("mid_rst_pc", bus.o_pc, 32'h0);
        chk("mid_rst_inst", bus.o_inst, 32'h0);
        chk("mid_rst_retired", bus.o_retired, 32'd0);
        do_instr(1'b0, 32'h0, 0, 1'b0, 1'b0, 10'h3C7, 8'h00);

        // randomized instruction stream against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic        chg;
            logic [31:0] tgt;
            logic        hlt;
            logic        wr;
            chg = 1'($urandom);
            tgt = $urandom_range(0, 192) * 4;
            hlt = ($urandom_range(0, 7) == 0);
            wr  = 1'($urandom);
            do_instr(chg, tgt, int'($urandom_range(0, 3)), hlt, wr,
                     10'h3C0 + 10'($urandom_range(0, 15)), 8'($urandom));
            if (m_halt) hold_and_resume(int'($urandom_range(1, 3)));
        end

        chk("no_stray_write", 32'(mem[10'h3F0]), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
